// File: rtl/psum_collector.sv
// Accumulates a configurable number of partial sums per output pixel, rescales and
// saturates each result, and queues it in a first-word-fall-through FIFO.
module psum_collector #(
   parameter int WIDTH      = 16,
   parameter int MAX_PASSES = 16,
   parameter int FRAC_SHIFT = 8,
   parameter int FIFO_DEPTH = 8,
   localparam int PW        = $clog2(MAX_PASSES + 1),
   localparam int A_WIDTH   = 2 * WIDTH + 1,
   localparam int ACC_WIDTH = A_WIDTH + PW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   input  logic [PW-1:0]      i_cfg_passes,
   input  logic [15:0]        i_cfg_outputs,
   input  logic [A_WIDTH-1:0] i_psum,
   input  logic               i_psum_valid,
   output logic [WIDTH-1:0]   o_out_data,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   output logic               o_fifo_full,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t               r_state;
   logic [PW-1:0]        r_passes;
   logic [15:0]          r_outputs;
   logic [ACC_WIDTH-1:0] r_acc;
   logic [PW-1:0]        r_pass_cnt;
   logic [15:0]          r_out_cnt;
   logic [WIDTH-1:0]     r_stage;
   logic                 r_stage_valid;
   logic [WIDTH-1:0]     r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_rd_ptr;
   logic [AW-1:0]        r_wr_ptr;
   logic [AW:0]          r_count;
   logic                 r_overflow;

   logic [ACC_WIDTH-1:0] w_final;
   logic [ACC_WIDTH-1:0] w_shifted;
   logic [WIDTH-1:0]     w_sat;
   logic                 w_last_pass;
   logic                 w_load;
   logic                 w_full;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_drop;

   assign w_final     = r_acc + ACC_WIDTH'(i_psum);
   assign w_shifted   = w_final >> FRAC_SHIFT;
   assign w_sat       = (|w_shifted[ACC_WIDTH-1:WIDTH]) ? '1 : w_shifted[WIDTH-1:0];
   assign w_last_pass = (r_pass_cnt >= r_passes - 1'b1);
   assign w_load      = (r_state == S_RUN) && i_psum_valid && w_last_pass;

   // A full FIFO still accepts the stage if the head leaves in the same cycle.
   assign w_full = (r_count == DEPTH_CNT);
   assign w_pop  = (r_count != '0) && i_out_ready;
   assign w_push = r_stage_valid && (!w_full || w_pop);
   assign w_drop = r_stage_valid && w_full && !w_pop;

   assign o_out_valid = (r_count != '0);
   assign o_out_data  = o_out_valid ? r_mem[r_rd_ptr] : '0;
   assign o_fifo_full = w_full;
   assign o_busy      = (r_state != S_IDLE);
   assign o_done      = (r_state == S_DONE);
   assign o_overflow  = r_overflow;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= r_stage;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_passes      <= '0;
         r_outputs     <= '0;
         r_acc         <= '0;
         r_pass_cnt    <= '0;
         r_out_cnt     <= '0;
         r_stage       <= '0;
         r_stage_valid <= 1'b0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         r_overflow    <= 1'b0;
      end else begin
         r_stage_valid <= w_load;
         if (w_load) r_stage <= w_sat;

         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;

         if (r_state == S_IDLE && i_start) r_overflow <= 1'b0;
         else if (w_drop)                  r_overflow <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_passes   <= (i_cfg_passes == '0) ? PW'(1) : i_cfg_passes;
                  r_outputs  <= i_cfg_outputs;
                  r_acc      <= '0;
                  r_pass_cnt <= '0;
                  r_out_cnt  <= '0;
                  r_state    <= (i_cfg_outputs == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (i_psum_valid) begin
                  if (!w_last_pass) begin
                     r_acc      <= w_final;
                     r_pass_cnt <= r_pass_cnt + 1'b1;
                  end else begin
                     r_acc      <= '0;
                     r_pass_cnt <= '0;
                     r_out_cnt  <= r_out_cnt + 16'd1;
                     if (r_out_cnt + 16'd1 == r_outputs) r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (!r_stage_valid && r_count == '0) r_state <= S_DONE;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_psum_collector.sv
// Scoreboard bench for psum_collector: stimulus queues expected results from a
// plain-arithmetic model, and a separate monitor checks every FIFO handshake.
module tb_psum_collector;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic [4:0]  i_cfg_passes;
   logic [15:0] i_cfg_outputs;
   logic [32:0] i_psum;
   logic        i_psum_valid;
   logic [15:0] o_out_data;
   logic        o_out_valid;
   logic        i_out_ready;
   logic        o_fifo_full;
   logic        o_busy;
   logic        o_done;
   logic        o_overflow;

   int total = 0;
   int bad   = 0;
   logic [15:0] expQ[$];
   bit randReady = 1'b0;

   psum_collector dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_cfg_passes(i_cfg_passes),
      .i_cfg_outputs(i_cfg_outputs), .i_psum(i_psum), .i_psum_valid(i_psum_valid),
      .o_out_data(o_out_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
      .o_fifo_full(o_fifo_full), .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(string name, longint act, longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: sum of all partial sums, logical shift by 8, clamp to 16 bits.
   function automatic logic [15:0] refResult(longint unsigned sum);
      longint unsigned s;
      s = sum >> 8;
      return (s > 64'd65535) ? 16'hFFFF : s[15:0];
   endfunction

   // Monitor: every accepted word must match the oldest expected result.
   always @(negedge clk) begin
      if (rst && o_out_valid && i_out_ready) begin
         if (expQ.size() == 0) checkOutput("unexpected_output", 1, 0);
         else checkOutput("out_data", o_out_data, expQ.pop_front());
      end
   end

   always @(posedge clk) begin
      if (randReady) begin
         #1;
         i_out_ready = ($urandom_range(3, 0) != 0);
      end
   end

   task automatic applyStimulus(logic valid, logic [32:0] value);
      i_psum_valid = valid;
      i_psum       = value;
      @(posedge clk); #1;
      i_psum_valid = 1'b0;
   endtask

   task automatic startTile(int passes, int outputs);
      i_cfg_passes  = 5'(passes);
      i_cfg_outputs = 16'(outputs);
      i_start       = 1'b1;
      @(posedge clk); #1;
      i_start       = 1'b0;
   endtask

   task automatic waitDone(string name, int budget);
      int n = 0;
      while (!o_done && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput(name, o_done, 1);
      @(posedge clk); #1;
      checkOutput({name, "_idle"}, o_busy, 0);
   endtask

   // Back-to-back finals with passes==1; keeps only what a non-draining FIFO can hold.
   task automatic burst(int n, int keep);
      logic [32:0] v;
      for (int k = 0; k < n; k++) begin
         v = 33'($urandom_range(16'hFFFF, 0)) << 8;
         if (k < keep) expQ.push_back(refResult(longint'(v)));
         i_psum_valid = 1'b1;
         i_psum       = v;
         @(posedge clk); #1;
      end
      i_psum_valid = 1'b0;
   endtask

   initial begin
      logic [32:0] v;
      longint unsigned sum;
      int passes, outs, effPasses;

      rst = 1'b0; i_start = 1'b0; i_cfg_passes = '0; i_cfg_outputs = '0;
      i_psum = '0; i_psum_valid = 1'b0; i_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", o_out_valid, 0);
      checkOutput("rst_out_data", o_out_data, 0);
      checkOutput("rst_fifo_full", o_fifo_full, 0);
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_done", o_done, 0);
      checkOutput("rst_overflow", o_overflow, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      // T1: single pass, check two-edge latency before releasing the consumer
      applyStimulus(1'b1, 33'h1234);
      checkOutput("idle_ignores_psum", o_out_valid, 0);
      startTile(1, 1);
      checkOutput("t1_busy", o_busy, 1);
      expQ.push_back(refResult(64'h1234));
      applyStimulus(1'b1, 33'h1234);
      checkOutput("t1_not_yet_valid", o_out_valid, 0);
      @(posedge clk); #1;
      checkOutput("t1_valid", o_out_valid, 1);
      checkOutput("t1_data", o_out_data, 16'h0012);
      i_out_ready = 1'b1;
      waitDone("t1_done", 20);

      // T2: four passes, nothing emitted until the last one
      startTile(4, 1);
      sum = 0;
      for (int p = 1; p <= 4; p++) begin
         v = 33'(p * 100) << 8;
         sum += longint'(v);
         if (p == 4) expQ.push_back(refResult(sum));
         applyStimulus(1'b1, v);
         @(posedge clk); #1;
         if (p < 4) checkOutput("t2_no_early_out", o_out_valid, 0);
      end
      checkOutput("t2_model", refResult(sum), 1000);
      waitDone("t2_done", 20);

      // T3: saturation and zero
      startTile(1, 2);
      expQ.push_back(16'hFFFF);
      applyStimulus(1'b1, 33'h1_0000_0000);
      expQ.push_back(16'h0000);
      applyStimulus(1'b1, 33'h0);
      waitDone("t3_done", 20);

      // T4: nine finals into a stalled FIFO of depth 8
      i_out_ready = 1'b0;
      startTile(1, 9);
      burst(9, 8);
      checkOutput("t4_full_after_8", o_fifo_full, 1);
      checkOutput("t4_no_overflow_yet", o_overflow, 0);
      @(posedge clk); #1;
      checkOutput("t4_overflow", o_overflow, 1);
      checkOutput("t4_still_full", o_fifo_full, 1);
      i_out_ready = 1'b1;
      waitDone("t4_done", 40);
      checkOutput("t4_overflow_sticky", o_overflow, 1);

      // T5: full FIFO with a pop on the same edge as the push
      i_out_ready = 1'b0;
      startTile(1, 9);
      checkOutput("t5_start_clears_ovf", o_overflow, 0);
      burst(9, 9);
      checkOutput("t5_full", o_fifo_full, 1);
      i_out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("t5_full_after_pushpop", o_fifo_full, 1);
      checkOutput("t5_no_overflow", o_overflow, 0);
      waitDone("t5_done", 40);

      // T6: reset mid-tile, then a clean restart
      startTile(4, 1);
      applyStimulus(1'b1, 33'hFFFF_FFFF);
      applyStimulus(1'b1, 33'hFFFF_FFFF);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("t6_out_valid", o_out_valid, 0);
      checkOutput("t6_busy", o_busy, 0);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checkOutput("t6_no_done", o_done, 0);
         @(posedge clk); #1;
      end
      startTile(4, 1);
      expQ.push_back(refResult(64'd4096));
      for (int p = 0; p < 4; p++) applyStimulus(1'b1, 33'd1024);
      waitDone("t6_done", 20);

      // Zero outputs completes immediately
      startTile(3, 0);
      checkOutput("zero_outputs_done", o_done, 1);
      @(posedge clk); #1;

      // Randomized tiles; at most 6 outputs per tile so the FIFO can never overflow
      randReady = 1'b1;
      for (int t = 0; t < 8; t++) begin
         passes    = (t == 0) ? 0 : $urandom_range(16, 1);
         effPasses = (passes == 0) ? 1 : passes;
         outs      = $urandom_range(6, 1);
         startTile(passes, outs);
         for (int o = 0; o < outs; o++) begin
            sum = 0;
            for (int p = 0; p < effPasses; p++) begin
               if ($urandom_range(1, 0) == 1) applyStimulus(1'b0, 33'($urandom()));
               if ($urandom_range(1, 0) == 1) v = {1'($urandom_range(1, 0)), 32'($urandom())};
               else v = 33'($urandom_range(32'h000F_FFFF, 0));
               sum += longint'(v);
               if (p == effPasses - 1) expQ.push_back(refResult(sum));
               applyStimulus(1'b1, v);
            end
         end
         waitDone("rand_done", 1000);
         checkOutput("rand_overflow", o_overflow, 0);
      end
      randReady = 1'b0;
      @(posedge clk); #1;
      i_out_ready = 1'b1;

      checkOutput("scoreboard_empty", expQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
